// File: rtl/gen_clk.sv
// Divides clk_8f by 4 (clk_2f) and by 8 (clk_f) from one 3-bit phase counter.
// Outputs are registered, so they change only just after a clk_8f rising edge.
module gen_clk (
    input  logic clk_8f,
    input  logic rst,
    input  logic enb,
    output logic clk_2f,
    output logic clk_f
);

    logic [2:0] cnt;
    logic [2:0] cnt_next;

    assign cnt_next = cnt + 3'd1;

    // Outputs take bits of the *next* phase so they line up with cnt after the edge;
    // a clk_f rise (phase 4) therefore lands on the same edge as a clk_2f fall.
    always_ff @(posedge clk_8f) begin
        if (rst) begin
            cnt    <= 3'd0;
            clk_2f <= 1'b0;
            clk_f  <= 1'b0;
        end else if (enb) begin
            cnt    <= cnt_next;
            clk_2f <= cnt_next[1];
            clk_f  <= cnt_next[2];
        end
    end

endmodule

// File: tb/tb_gen_clk.sv
// Self-checking bench for gen_clk: directed scenarios plus randomized rst/enb
// compared against an edge-counting reference model.
module tb_gen_clk;

    logic clk_8f = 1'b0;
    logic rst    = 1'b0;
    logic enb    = 1'b0;
    logic clk_2f;
    logic clk_f;

    int checks = 0;
    int errors = 0;

    // Reference: number of enabled edges since reset, modulo the clk_f period.
    int k = 0;
    logic [1:0] exp_q[$];

    gen_clk dut (
        .clk_8f (clk_8f),
        .rst    (rst),
        .enb    (enb),
        .clk_2f (clk_2f),
        .clk_f  (clk_f)
    );

    always #2 clk_8f = ~clk_8f;

    function automatic logic model_2f(input int ph);
        return ((ph % 4) >= 2);
    endfunction

    function automatic logic model_f(input int ph);
        return ((ph % 8) >= 4);
    endfunction

    // One clk_8f rising edge with the given inputs; returns 1 ns after the edge.
    task automatic tick(input logic r, input logic e);
        rst = r;
        enb = e;
        @(posedge clk_8f);
        if (r) k = 0;
        else if (e) k = (k + 1) % 8;
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
        checks++;
        if (clk_2f !== 1'b0 || clk_f !== 1'b0) begin
            errors++;
            $display("FAIL reset: clk_2f=%b clk_f=%b expected 0 0", clk_2f, clk_f);
        end
    endtask

    task automatic test_free_run();
        int first_2f = 0;
        int first_f = 0;
        int rises_2f = 0;
        int rises_f = 0;
        logic prev_2f;
        logic prev_f;
        tick(1'b1, 1'b0);
        prev_2f = clk_2f;
        prev_f  = clk_f;
        for (int e = 1; e <= 16; e++) begin
            tick(1'b0, 1'b1);
            checks++;
            if (clk_2f !== model_2f(k) || clk_f !== model_f(k)) begin
                errors++;
                $display("FAIL free_run edge %0d: got %b%b expected %b%b",
                         e, clk_2f, clk_f, model_2f(k), model_f(k));
            end
            if (clk_2f && !prev_2f) begin
                rises_2f++;
                if (first_2f == 0) first_2f = e;
            end
            if (clk_f && !prev_f) begin
                rises_f++;
                if (first_f == 0) first_f = e;
            end
            prev_2f = clk_2f;
            prev_f  = clk_f;
        end
        checks++;
        if (first_2f != 2 || first_f != 4) begin
            errors++;
            $display("FAIL first_rise: clk_2f at %0d clk_f at %0d expected 2 and 4", first_2f, first_f);
        end
        checks++;
        if (rises_2f != 4 || rises_f != 2) begin
            errors++;
            $display("FAIL rise_count: clk_2f %0d clk_f %0d expected 4 and 2", rises_2f, rises_f);
        end
    endtask

    task automatic test_freeze();
        tick(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b1);
        checks++;
        if (clk_2f !== 1'b0 || clk_f !== 1'b1) begin
            errors++;
            $display("FAIL freeze_pre: got %b%b expected 01", clk_2f, clk_f);
        end
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, 1'b0);
            checks++;
            if (clk_2f !== 1'b0 || clk_f !== 1'b1) begin
                errors++;
                $display("FAIL freeze_hold %0d: got %b%b expected 01", i, clk_2f, clk_f);
            end
        end
        tick(1'b0, 1'b1);
        checks++;
        if (clk_2f !== 1'b1 || clk_f !== 1'b1) begin
            errors++;
            $display("FAIL freeze_resume: got %b%b expected 11", clk_2f, clk_f);
        end
    endtask

    task automatic test_reset_mid_run();
        tick(1'b1, 1'b0);
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b1);
        checks++;
        if (clk_2f !== 1'b1 || clk_f !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre: got %b%b expected 11", clk_2f, clk_f);
        end
        tick(1'b1, 1'b1);
        checks++;
        if (clk_2f !== 1'b0 || clk_f !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got %b%b expected 00", clk_2f, clk_f);
        end
        tick(1'b0, 1'b1);
        checks++;
        if (clk_2f !== 1'b0 || clk_f !== 1'b0) begin
            errors++;
            $display("FAIL mid_e1: got %b%b expected 00", clk_2f, clk_f);
        end
        tick(1'b0, 1'b1);
        checks++;
        if (clk_2f !== 1'b1 || clk_f !== 1'b0) begin
            errors++;
            $display("FAIL mid_e2: got %b%b expected 10", clk_2f, clk_f);
        end
    endtask

    task automatic test_wrap();
        tick(1'b1, 1'b0);
        for (int i = 0; i < 8; i++) tick(1'b0, 1'b1);
        checks++;
        if (clk_2f !== 1'b0 || clk_f !== 1'b0) begin
            errors++;
            $display("FAIL wrap_e8: got %b%b expected 00", clk_2f, clk_f);
        end
        tick(1'b0, 1'b1);
        checks++;
        if (clk_2f !== 1'b0 || clk_f !== 1'b0) begin
            errors++;
            $display("FAIL wrap_e9: got %b%b expected 00", clk_2f, clk_f);
        end
        tick(1'b0, 1'b1);
        checks++;
        if (clk_2f !== 1'b1 || clk_f !== 1'b0) begin
            errors++;
            $display("FAIL wrap_e10: got %b%b expected 10", clk_2f, clk_f);
        end
    endtask

    task automatic test_priority();
        tick(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b1);
            checks++;
            if (clk_2f !== 1'b0 || clk_f !== 1'b0) begin
                errors++;
                $display("FAIL priority %0d: got %b%b expected 00", i, clk_2f, clk_f);
            end
        end
        // Counter must also be at phase 0: four enabled edges reach the first clk_f rise.
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1);
        checks++;
        if (clk_2f !== 1'b0 || clk_f !== 1'b1) begin
            errors++;
            $display("FAIL priority_phase: got %b%b expected 01", clk_2f, clk_f);
        end
    endtask

    task automatic test_random();
        logic [1:0] got;
        logic [1:0] exp;
        logic r;
        logic e;
        tick(1'b1, 1'b0);
        for (int i = 0; i < 300; i++) begin
            r = ($urandom_range(0, 19) == 0);
            e = ($urandom_range(0, 3) != 0);
            tick(r, e);
            exp_q.push_back({model_2f(k), model_f(k)});
            got = {clk_2f, clk_f};
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL random step %0d: got %b expected %b", i, got, exp);
            end
        end
    endtask

    initial begin
        repeat (2) @(negedge clk_8f);
        test_reset();
        test_free_run();
        test_freeze();
        test_reset_mid_run();
        test_wrap();
        test_priority();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
